idct_mac_unit: RTL and testbench
================================

// Module: idct_mac_unit
// PURPOSE
//  Inverse-DCT multiply-accumulate unit, the decode-side counterpart of the forward DCT MAC unit.
//  Streams N dequantised coefficients and N cosine constants per output sample.
//  Produces one rounded, saturated spatial-domain sample per N accepted terms.
//  Sits inside each 1-D IDCT row/column unit, feeding the transpose buffer.
// PARAMETERS
//  N        8   terms per output sample (must be >= 2)
//  COEF_W  12   signed coefficient width
//  CONST_W 12   signed cosine constant width, fixed point with FRAC fraction bits
//  FRAC    11   fraction bits removed at output
//  ACC_W   27   accumulator width, must be >= COEF_W+CONST_W+clog2(N)
//  OUT_W   10   signed output sample width
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  sync_clr   in   1        synchronous flush: term counter, pipeline, out_valid
//  in_valid   in   1        term valid
//  in_ready   out  1        term accepted when in_valid && in_ready
//  in_coef    in   COEF_W   signed coefficient
//  in_const   in   CONST_W  signed cosine constant
//  out_valid  out  1        result valid; held until out_ready
//  out_ready  in   1        downstream accept
//  out_data   out  OUT_W    signed saturated sample
// BEHAVIOUR
//  Single clock domain: clk. Reset is asynchronous, active-low (rst_n).
//  Reset values: out_valid=0, out_data=0, cnt=0, s1_valid=0, acc=0; in_ready=1 out of reset.
//  Term counter cnt 0..N-1, advances on each accepted term, wraps N-1 -> 0.
//    A term is tagged first at cnt==0 and last at cnt==N-1.
//  Stage 1 (register): prod = in_coef*in_const (full signed width), plus first/last tags, s1_valid.
//  Stage 2 (accumulate): sum = s1_first ? prod : acc+prod (ACC_W, sign-extended); acc <= sum.
//    On s1_last: out_data <= sat(round(sum)) and out_valid <= 1.
//    round(x) = (x + 2^(FRAC-1)) >>> FRAC, i.e. round half toward +inf.
//    sat clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  Latency: out_valid rises 2 cycles after the cycle the last term is accepted.
//  Throughput: one term per cycle; one result every N cycles with no stalls.
//  Output handshake: out_valid falls after the out_valid && out_ready cycle,
//    unless a new result loads in that same cycle, in which case it stays 1.
//    out_data is stable while out_valid && !out_ready.
//  Stall: stall = s1_valid && s1_last && out_valid && !out_ready.
//    During a stall, stage 1 holds and acc holds. in_ready = !stall.
//    Non-last products never stall.
//  Simultaneous drain and load: out_ready=1 with a pending s1_last loads the new result,
//    with no bubble.
//  sync_clr: takes priority over all handshakes. Next cycle cnt=0, s1_valid=0, out_valid=0.
//    The term presented in the sync_clr cycle is discarded.
//  rst_n asserted mid-block: partial sum is discarded. First term after release is tagged first.
//  No overflow wrap: ACC_W sizing guarantees an exact sum, so only the output saturates.
// TESTING
//  1 Eight terms coef=100, const=1024, out_ready=1 -> out_data=400, out_valid 2 cycles after last term.
//  2 Term0 coef=1, const=1024; terms 1-7 const=0 -> out_data=1 (0.5 rounds up). Same with coef=-1 -> 0.
//  3 Eight terms 2047*2047 -> 511. Eight terms -2048*2047 -> -512 (saturation).
//  4 out_ready=0, 16 back-to-back terms ->
//    in_ready drops while the 2nd last-term sits in stage 1, first result stays stable.
//    out_ready=1 -> both results in order, none lost.
//  5 sync_clr after 5 terms, then 8 fresh terms (coef=100, const=1024) -> single result 400.
//    Same sequence with rst_n pulsed instead of sync_clr -> 400, out_valid=0 during reset.
//  6 Random coef/const, random in_valid/out_ready gaps, 1000 blocks -> matches a golden model
//    computing sat(round(sum)).

Source files
------------

// File: rtl/idct_mac_unit.sv
// idct_mac_unit: inverse-DCT multiply-accumulate unit.
// Two stages: registered product, then accumulate/round/saturate.
module idct_mac_unit #(
  parameter int N       = 8,
  parameter int COEF_W  = 12,
  parameter int CONST_W = 12,
  parameter int FRAC    = 11,
  parameter int ACC_W   = 27,
  parameter int OUT_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sync_clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COEF_W-1:0]  in_coef,
  input  logic [CONST_W-1:0] in_const,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data
);

  localparam int PROD_W = COEF_W + CONST_W;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int SAT_HI = 2 ** (OUT_W - 1) - 1;
  localparam int SAT_LO = -(2 ** (OUT_W - 1));
  localparam int HALF   = 2 ** (FRAC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_first_q, s1_first_d;
  logic                     s1_last_q, s1_last_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;

  logic                     stall;
  logic                     accept;
  logic signed [PROD_W-1:0] mul;
  logic signed [ACC_W-1:0]  prod_x;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W:0]    rnd;
  logic signed [ACC_W:0]    shr;
  logic [OUT_W-1:0]         sat;

  // A finished sum can only block when the output register is full.
  assign stall  = s1_valid_q & s1_last_q & out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign accept = in_valid & ~stall;

  assign mul    = $signed(in_coef) * $signed(in_const);
  assign prod_x = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
  assign sum    = s1_first_q ? prod_x : acc_q + prod_x;

  // Round half toward +inf, then clamp to the output range.
  assign rnd = {sum[ACC_W-1], sum} + $signed((ACC_W + 1)'(HALF));
  assign shr = rnd >>> FRAC;

  // Saturate the rounded sum into OUT_W bits.
  always_comb begin
    sat = OUT_W'(shr);
    if (shr > $signed((ACC_W + 1)'(SAT_HI)))
      sat = OUT_W'(SAT_HI);
    else if (shr < $signed((ACC_W + 1)'(SAT_LO)))
      sat = OUT_W'(SAT_LO);
  end

  // Stage 1 next state: term counter and product register.
  always_comb begin
    cnt_d      = cnt_q;
    s1_valid_d = s1_valid_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    prod_d     = prod_q;
    if (sync_clr) begin
      cnt_d      = '0;
      s1_valid_d = 1'b0;
    end else if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        prod_d     = mul;
        s1_first_d = (cnt_q == '0);
        s1_last_d  = (cnt_q == CNT_MAX);
        cnt_d      = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage 2 next state: accumulator and output register.
  always_comb begin
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (sync_clr) begin
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready)
        out_valid_d = 1'b0;
      if (s1_valid_q && !stall) begin
        acc_d = sum;
        if (s1_last_q) begin
          out_data_d  = sat;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_idct_mac_unit.sv
// tb_idct_mac_unit: directed and randomised checks
// for the IDCT multiply-accumulate unit.
module tb_idct_mac_unit;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_coef = '0;
  logic [11:0] in_const = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [9:0]  out_data;

  int n_tests = 0;
  int n_fail  = 0;

  bit     mon_en = 1'b0;
  longint msum = 0;
  int     mcnt = 0;
  int     outs = 0;
  longint expq[$];

  always #5 clk = ~clk;

  idct_mac_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_clr (sync_clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_coef  (in_coef),
    .in_const (in_const),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic check(string tag, longint got, longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint golden(longint s);
    longint r;
    r = (s + 1024) >>> 11;
    if (r > 511) r = 511;
    if (r < -512) r = -512;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one term and hold it until accepted; in_valid stays high.
  task automatic send(int c, int k);
    bit r;
    in_valid = 1'b1;
    in_coef  = 12'(c);
    in_const = 12'(k);
    for (int i = 0; i < 50; i++) begin
      r = in_ready;
      tick();
      if (r) return;
    end
    check("send_timeout", 0, 1);
  endtask

  task automatic block8(int c, int k);
    for (int i = 0; i < N; i++) send(c, k);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(string tag, int exp);
    int i;
    i = 0;
    while (!out_valid && i < 30) begin
      tick();
      i++;
    end
    check({tag, "_valid"}, longint'(out_valid), 1);
    check(tag, longint'($signed(out_data)), exp);
    tick();
  endtask

  task automatic quiet(string tag, int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check(tag, seen, 0);
  endtask

  // Scoreboard used during the randomised phase.
  always @(posedge clk) begin
    if (mon_en) begin
      if (in_valid && in_ready) begin
        longint p;
        p = longint'($signed(in_coef)) * longint'($signed(in_const));
        msum = (mcnt == 0) ? p : msum + p;
        if (mcnt == N - 1) begin
          expq.push_back(golden(msum));
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
      if (out_valid && out_ready) begin
        outs++;
        if (expq.size() == 0)
          check("rand_extra", 1, 0);
        else
          check("rand_data", longint'($signed(out_data)), expq.pop_front());
      end
    end
  end

  initial begin
    int acc_terms;
    int guard;
    bit a;

    // Reset state
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic block and latency
    out_ready = 1'b1;
    for (int i = 0; i < N - 1; i++) send(100, 1024);
    send(100, 1024);
    in_valid = 1'b0;
    check("lat_early", longint'(out_valid), 0);
    tick();
    check("lat_valid", longint'(out_valid), 1);
    check("basic_400", longint'($signed(out_data)), 400);
    tick();
    check("lat_drop", longint'(out_valid), 0);

    // Rounding of exactly one half
    send(1, 1024);
    for (int i = 1; i < N; i++) send(5, 0);
    in_valid = 1'b0;
    expect_out("round_pos", 1);
    send(-1, 1024);
    for (int i = 1; i < N; i++) send(5, 0);
    in_valid = 1'b0;
    expect_out("round_neg", 0);

    // Saturation both ways
    block8(2047, 2047);
    expect_out("sat_hi", 511);
    block8(-2048, 2047);
    expect_out("sat_lo", -512);

    // Backpressure: two blocks with output blocked
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(100, 1024);
    for (int i = 0; i < N; i++) send(-50, 1024);
    in_valid = 1'b0;
    check("bp_in_ready", longint'(in_ready), 0);
    check("bp_valid", longint'(out_valid), 1);
    check("bp_first", longint'($signed(out_data)), 400);
    tick();
    tick();
    check("bp_hold", longint'($signed(out_data)), 400);
    check("bp_hold_rdy", longint'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    check("bp_second_v", longint'(out_valid), 1);
    check("bp_second", longint'($signed(out_data)), -200);
    check("bp_release", longint'(in_ready), 1);
    tick();
    check("bp_empty", longint'(out_valid), 0);

    // Mid-block synchronous flush
    for (int i = 0; i < 5; i++) send(300, 1024);
    sync_clr = 1'b1;
    in_coef  = 12'd7;
    tick();
    sync_clr = 1'b0;
    in_valid = 1'b0;
    check("clr_valid", longint'(out_valid), 0);
    block8(100, 1024);
    expect_out("clr_result", 400);
    quiet("clr_no_extra", 12);

    // Mid-block asynchronous reset
    for (int i = 0; i < 5; i++) send(300, 1024);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst2_valid", longint'(out_valid), 0);
    check("rst2_rdy", longint'(in_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    block8(100, 1024);
    expect_out("rst2_result", 400);
    quiet("rst2_no_extra", 12);

    // Randomised traffic against the golden model
    mon_en = 1'b1;
    acc_terms = 0;
    guard = 0;
    while (acc_terms < 1000 * N && guard < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_coef   = 12'($urandom_range(0, 4095));
      in_const  = 12'($urandom_range(0, 4095));
      a = in_valid && in_ready;
      tick();
      if (a) acc_terms++;
      guard++;
    end
    check("rand_terms", acc_terms, 1000 * N);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();
    check("rand_blocks", outs, 1000);
    check("rand_left", expq.size(), 0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
